// File: rtl/shared_bank_allocator.sv
// shared_bank_allocator: hands out shared flit-buffer banks to input ports,
// one bank per port, tracks bank occupancy, returns one shared-VC credit per
// popped flit and drains a released bank to empty before it is reusable.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_ip              level request for a bank (held until gnt_ip)
//   push_ip / pop_ip    one flit written to / read from the port's bank
//   release_ip          one-cycle pulse: port gives up its bank
//   gnt_ip, gnt_bank    registered one-hot grant pulse and granted bank index
//   owns_ip             port currently owns a bank (memory_bank_grant mirrors it)
//   credit_for_shared   registered one-cycle credit per accepted pop
//   free_banks          number of FREE banks after the last edge
//   error               sticky protocol error
//   almost_full_ip      (SHARED_BANK_WATERMARK_EN only) owned bank count >= bank_size-2
//
// Optional feature macro: SHARED_BANK_WATERMARK_EN.

module shared_bank_allocator #(
    parameter int unsigned num_ports = 5,
    parameter int unsigned num_banks = 6,
    parameter int unsigned bank_size = 10,
    localparam int unsigned bank_idx_width = (num_banks > 1) ? $clog2(num_banks) : 1,
    localparam int unsigned count_width    = $clog2(bank_size + 1),
    localparam int unsigned free_width     = $clog2(num_banks + 1),
    localparam int unsigned port_idx_width = (num_ports > 1) ? $clog2(num_ports) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [num_ports-1:0]      req_ip,
    input  logic [num_ports-1:0]      push_ip,
    input  logic [num_ports-1:0]      pop_ip,
    input  logic [num_ports-1:0]      release_ip,
    output logic [num_ports-1:0]      gnt_ip,
    output logic [bank_idx_width-1:0] gnt_bank,
    output logic [num_ports-1:0]      owns_ip,
    output logic [num_ports-1:0]      memory_bank_grant,
    output logic [num_ports-1:0]      credit_for_shared,
    output logic [free_width-1:0]     free_banks,
    output logic                      error
`ifdef SHARED_BANK_WATERMARK_EN
    ,
    output logic [num_ports-1:0]      almost_full_ip
`endif
);

    typedef enum logic [1:0] {
        BANK_FREE  = 2'd0,
        BANK_OWNED = 2'd1,
        BANK_DRAIN = 2'd2
    } bank_state_e;

    bank_state_e                state_q     [num_banks];
    bank_state_e                state_d     [num_banks];
    logic [port_idx_width-1:0]  owner_q     [num_banks];
    logic [port_idx_width-1:0]  owner_d     [num_banks];
    logic [count_width-1:0]     count_q     [num_banks];
    logic [count_width-1:0]     count_d     [num_banks];
    logic [bank_idx_width-1:0]  port_bank_q [num_ports];
    logic [bank_idx_width-1:0]  port_bank_d [num_ports];
    logic [num_ports-1:0]       owns_q, owns_d;
    logic [port_idx_width-1:0]  rr_ptr_q, rr_ptr_d;
    logic [num_ports-1:0]       gnt_ip_q, gnt_ip_d;
    logic [bank_idx_width-1:0]  gnt_bank_q, gnt_bank_d;
    logic [num_ports-1:0]       credit_q, credit_d;
    logic [free_width-1:0]      free_q, free_d;
    logic                       error_q, error_d;

    // Pop target per port: the owned bank, else the lowest DRAINING bank it still links to
    logic [num_ports-1:0]       pop_hit;
    logic [bank_idx_width-1:0]  pop_bank [num_ports];

    always_comb begin
        pop_hit = '0;
        for (int unsigned p = 0; p < num_ports; p++) begin
            pop_bank[p] = port_bank_q[p];
            if (owns_q[p]) begin
                pop_hit[p] = 1'b1;
            end else begin
                for (int b = int'(num_banks) - 1; b >= 0; b--) begin
                    if (state_q[b] == BANK_DRAIN && owner_q[b] == port_idx_width'(p)) begin
                        pop_hit[p]  = 1'b1;
                        pop_bank[p] = bank_idx_width'(b);
                    end
                end
            end
        end
    end

    // Next-state: flit traffic, releases, draining, then arbitration on pre-edge state
    always_comb begin
        logic [bank_idx_width-1:0] tgt;
        logic [bank_idx_width-1:0] free_idx;
        logic [port_idx_width-1:0] win;
        logic [port_idx_width-1:0] cand;
        logic                      do_push;
        logic                      do_pop;
        logic                      free_any;
        logic                      found;
        int unsigned               nfree;

        state_d     = state_q;
        owner_d     = owner_q;
        count_d     = count_q;
        port_bank_d = port_bank_q;
        owns_d      = owns_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_ip_d    = '0;
        gnt_bank_d  = '0;
        credit_d    = '0;
        error_d     = error_q;
        tgt         = '0;
        free_idx    = '0;
        win         = '0;
        cand        = '0;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        free_any    = 1'b0;
        found       = 1'b0;
        nfree       = 0;

        for (int unsigned p = 0; p < num_ports; p++) begin
            tgt     = pop_bank[p];
            do_push = push_ip[p] && owns_q[p] && !release_ip[p];
            do_pop  = pop_ip[p] && pop_hit[p];
            if ((push_ip[p] && !owns_q[p]) || (release_ip[p] && !owns_q[p]) ||
                (push_ip[p] && release_ip[p]) || (pop_ip[p] && !pop_hit[p])) begin
                error_d = 1'b1;
            end
            // Push and pop together pass a flit straight through: count holds
            if (do_push && do_pop) begin
                credit_d[p] = 1'b1;
            end else if (do_push) begin
                if (count_q[tgt] == count_width'(bank_size)) begin
                    error_d = 1'b1;
                end else begin
                    count_d[tgt] = count_q[tgt] + count_width'(1);
                end
            end else if (do_pop) begin
                if (count_q[tgt] == '0) begin
                    error_d = 1'b1;
                end else begin
                    count_d[tgt] = count_q[tgt] - count_width'(1);
                    credit_d[p]  = 1'b1;
                end
            end
            if (release_ip[p] && owns_q[p]) begin
                owns_d[p]    = 1'b0;
                state_d[tgt] = (count_d[tgt] == '0) ? BANK_FREE : BANK_DRAIN;
            end
        end

        for (int unsigned b = 0; b < num_banks; b++) begin
            if (state_d[b] == BANK_DRAIN && count_d[b] == '0) begin
                state_d[b] = BANK_FREE;
            end
        end

        // Lowest-index bank that was FREE before this edge
        for (int b = int'(num_banks) - 1; b >= 0; b--) begin
            if (state_q[b] == BANK_FREE) begin
                free_any = 1'b1;
                free_idx = bank_idx_width'(b);
            end
        end

        for (int unsigned i = 0; i < num_ports; i++) begin
            cand = port_idx_width'((32'(rr_ptr_q) + i) % num_ports);
            if (!found && req_ip[cand] && !owns_q[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        if (found && free_any) begin
            gnt_ip_d[win]     = 1'b1;
            gnt_bank_d        = free_idx;
            owns_d[win]       = 1'b1;
            port_bank_d[win]  = free_idx;
            state_d[free_idx] = BANK_OWNED;
            owner_d[free_idx] = win;
            count_d[free_idx] = '0;
            rr_ptr_d          = port_idx_width'((32'(win) + 1) % num_ports);
        end

        for (int unsigned b = 0; b < num_banks; b++) begin
            if (state_d[b] == BANK_FREE) begin
                nfree = nfree + 1;
            end
        end
        free_d = free_width'(nfree);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < num_banks; b++) begin
                state_q[b] <= BANK_FREE;
                owner_q[b] <= '0;
                count_q[b] <= '0;
            end
            for (int unsigned p = 0; p < num_ports; p++) begin
                port_bank_q[p] <= '0;
            end
            owns_q     <= '0;
            rr_ptr_q   <= '0;
            gnt_ip_q   <= '0;
            gnt_bank_q <= '0;
            credit_q   <= '0;
            free_q     <= free_width'(num_banks);
            error_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            count_q     <= count_d;
            port_bank_q <= port_bank_d;
            owns_q      <= owns_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_ip_q    <= gnt_ip_d;
            gnt_bank_q  <= gnt_bank_d;
            credit_q    <= credit_d;
            free_q      <= free_d;
            error_q     <= error_d;
        end
    end

`ifdef SHARED_BANK_WATERMARK_EN
    logic [num_ports-1:0] af_q, af_d;

    // Watermark on the post-edge occupancy of the bank each port will own
    always_comb begin
        af_d = '0;
        for (int unsigned p = 0; p < num_ports; p++) begin
            af_d[p] = owns_d[p] &&
                      (count_d[port_bank_d[p]] >= count_width'(bank_size - 2));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            af_q <= '0;
        end else begin
            af_q <= af_d;
        end
    end

    assign almost_full_ip = af_q;
`endif

    assign gnt_ip            = gnt_ip_q;
    assign gnt_bank          = gnt_bank_q;
    assign owns_ip           = owns_q;
    assign memory_bank_grant = owns_q;
    assign credit_for_shared = credit_q;
    assign free_banks        = free_q;
    assign error             = error_q;

endmodule
